idct_seq_ctrl: RTL and testbench

IDCT_SEQ_CTRL -- requirements
Module: idct_seq_ctrl

---
 rtl/idct_pkg.sv | 10 +
 rtl/idct_tag_dly.sv | 33 +++
 rtl/idct_seq_ctrl.sv | 84 ++++++++
 tb/tb_idct_seq_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: shared state encoding, latency and rounding constants for the IDCT sequencer.
package idct_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  localparam int NGRP_DEF = 4;
  localparam int LAT = 4;
  localparam logic [3:0] ROW_SHIFT = 4'd7;
  localparam logic [3:0] COL_SHIFT = 4'd12;
  localparam logic signed [24:0] ROW_ADD = 25'sd64;
  localparam logic signed [24:0] COL_ADD = 25'sd2048;
endpackage

// File: rtl/idct_tag_dly.sv
// idct_tag_dly: valid/group/block tag shift register; tap 0 is one cycle behind the input.
module idct_tag_dly #(
  parameter int DEPTH = 4,
  parameter int GW = 2,
  parameter int BW = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               v_i,
  input  logic [GW-1:0]      grp_i,
  input  logic [BW-1:0]      blk_i,
  output logic [DEPTH-1:0]   v_o,
  output logic [DEPTH*GW-1:0] grp_o,
  output logic [BW-1:0]      blk_o
);
  logic [DEPTH-1:0] v_q;
  logic [DEPTH*GW-1:0] grp_q;
  logic [DEPTH*BW-1:0] blk_q;
  // Tags are zeroed when invalid so downstream indices read 0 without extra gating.
  always_ff @(posedge clk)
    if (clr) begin
      v_q <= '0;
      grp_q <= '0;
      blk_q <= '0;
    end else begin
      v_q <= {v_q[DEPTH-2:0], v_i};
      grp_q <= {grp_q[(DEPTH-1)*GW-1:0], v_i ? grp_i : GW'(0)};
      blk_q <= {blk_q[(DEPTH-1)*BW-1:0], v_i ? blk_i : BW'(0)};
    end
  assign v_o = v_q;
  assign grp_o = grp_q;
  assign blk_o = blk_q[DEPTH*BW-1 -: BW];
endmodule

// File: rtl/idct_seq_ctrl.sv
// idct_seq_ctrl: sequences row/column IDCT passes, staggering lane tags and tracking output latency.
module idct_seq_ctrl
  import idct_pkg::*;
#(
  parameter int NGRP = NGRP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pass_sel,
  input  logic [3:0]         n_blk,
  output logic               busy,
  output logic [3:0]         lane_vld,
  output logic [1:0]         lane1_grp,
  output logic [1:0]         lane2_grp,
  output logic [1:0]         lane3_grp,
  output logic [1:0]         lane4_grp,
  output logic [3:0]         shift,
  output logic signed [24:0] add,
  output logic               out_valid,
  output logic [1:0]         out_grp,
  output logic [3:0]         out_blk,
  output logic               done
);
  localparam logic [1:0] GMAX = 2'(NGRP - 1);
  state_e state_q, state_d;
  logic [1:0] grp_q, grp_d;
  logic [3:0] blk_q, blk_d, nblk_q, nblk_d, shift_q, shift_d;
  logic signed [24:0] add_q, add_d;
  logic launch, wrap, last, acc;
  logic [LAT-1:0] tv;
  logic [LAT*2-1:0] tg;
  logic [3:0] tb;
  always_comb begin
    launch = state_q == S_RUN;
    acc = state_q == S_IDLE && start;
    wrap = launch && grp_q == GMAX;
    last = wrap && blk_q == nblk_q - 4'd1;
    done = state_q == S_DRAIN && tv[LAT-1] && tg[LAT*2-1 -: 2] == GMAX && tb == nblk_q - 4'd1;
    state_d = acc ? S_RUN : last ? S_DRAIN : done ? S_IDLE : state_q;
    grp_d = wrap || !launch ? 2'd0 : grp_q + 2'd1;
    blk_d = !launch || last ? 4'd0 : wrap ? blk_q + 4'd1 : blk_q;
    nblk_d = acc ? (n_blk == 4'd0 ? 4'd1 : n_blk) : nblk_q;
    shift_d = acc ? (pass_sel ? COL_SHIFT : ROW_SHIFT) : shift_q;
    add_d = acc ? (pass_sel ? COL_ADD : ROW_ADD) : add_q;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= S_IDLE;
      grp_q <= '0;
      blk_q <= '0;
      nblk_q <= '0;
      shift_q <= '0;
      add_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q <= grp_d;
      blk_q <= blk_d;
      nblk_q <= nblk_d;
      shift_q <= shift_d;
      add_q <= add_d;
    end
  idct_tag_dly #(.DEPTH(LAT), .GW(2), .BW(4)) u_dly (
    .clk(clk),
    .clr(!reset),
    .v_i(launch),
    .grp_i(grp_q),
    .blk_i(blk_q),
    .v_o(tv),
    .grp_o(tg),
    .blk_o(tb)
  );
  assign busy = state_q != S_IDLE;
  assign lane_vld = {tv[2:0], launch};
  assign lane1_grp = launch ? grp_q : 2'd0;
  assign lane2_grp = tg[1:0];
  assign lane3_grp = tg[3:2];
  assign lane4_grp = tg[5:4];
  assign out_valid = tv[LAT-1];
  assign out_grp = tg[LAT*2-1 -: 2];
  assign out_blk = tb;
  assign shift = shift_q;
  assign add = add_q;
endmodule

// File: tb/tb_idct_seq_ctrl.sv
// tb_idct_seq_ctrl: randomized bench with a cycle-schedule reference model and an output-tag scoreboard.
module tb_idct_seq_ctrl;
  localparam int NG = 4;
  logic clk = 0, reset = 0, start = 0, pass_sel = 0;
  logic [3:0] n_blk = 0;
  logic busy, out_valid, done;
  logic [3:0] lane_vld, shift, out_blk;
  logic [1:0] lane1_grp, lane2_grp, lane3_grp, lane4_grp, out_grp;
  logic signed [24:0] add;
  idct_seq_ctrl #(.NGRP(NG)) dut (
    .clk(clk), .reset(reset), .start(start), .pass_sel(pass_sel), .n_blk(n_blk),
    .busy(busy), .lane_vld(lane_vld), .lane1_grp(lane1_grp), .lane2_grp(lane2_grp),
    .lane3_grp(lane3_grp), .lane4_grp(lane4_grp), .shift(shift), .add(add),
    .out_valid(out_valid), .out_grp(out_grp), .out_blk(out_blk), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] blk; logic [1:0] grp; logic last;} tag_t;
  tag_t q[$];
  int checks = 0, failures = 0;
  int t = 0, s = -1000, len = 0;
  int e_shift = 0, e_add = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, t, act, exp);
    end
  endtask
  function automatic int in_rng(input int x, input int lo, input int hi);
    return (x >= lo && x <= hi) ? 1 : 0;
  endfunction
  function automatic int lane_grp(input int k);
    return k == 1 ? int'(lane1_grp) : k == 2 ? int'(lane2_grp) : k == 3 ? int'(lane3_grp) : int'(lane4_grp);
  endfunction
  // Reference model: a pass accepted at the end of cycle c launches in cycles c+1..c+len,
  // lane k trails by k-1 cycles, results land 4 cycles after launch, busy ends with the last result.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      s = -1000; len = 0; e_shift = 0; e_add = 0; q.delete();
    end else if (start && in_rng(t, s, s + len + 3) == 0) begin
      s = t + 1;
      len = (n_blk == 0 ? 1 : int'(n_blk)) * NG;
      e_shift = pass_sel ? 12 : 7;
      e_add = pass_sel ? 2048 : 64;
      for (int i = 0; i < len; i++) q.push_back('{blk: 4'(i / NG), grp: 2'(i % NG), last: i == len - 1});
    end
    t++;
    #1;
    chk("busy", busy, in_rng(t, s, s + len + 3));
    for (int k = 1; k <= 4; k++) begin
      int lv;
      lv = in_rng(t, s + k - 1, s + k - 2 + len);
      chk($sformatf("lane%0d_vld", k), lane_vld[k-1], lv);
      chk($sformatf("lane%0d_grp", k), lane_grp(k), lv != 0 ? (t - s - k + 1) % NG : 0);
    end
    chk("out_valid", out_valid, in_rng(t, s + 4, s + len + 3));
    chk("shift", shift, e_shift);
    chk("add", add, e_add);
  end
  // Scoreboard monitor: every presented result must match the next queued tag.
  initial forever begin
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out cycle=%0d grp=%0d blk=%0d want=none", t, out_grp, out_blk);
      end else begin
        tag_t e;
        e = q.pop_front();
        chk("out_grp", out_grp, e.grp);
        chk("out_blk", out_blk, e.blk);
        chk("done", done, e.last);
      end
    end else begin
      chk("done_idle", done, 0);
      if (out_grp != 0 || out_blk != 0) chk("out_tag_zero", {out_blk, out_grp}, 0);
    end
  end
  task automatic go(input logic ps, input logic [3:0] n);
    start = 1; pass_sel = ps; n_blk = n;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_c(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    wait_c(3);
    reset = 1;
    go(0, 4'd1); wait_c(12);
    go(1, 4'd3); wait_c(20);
    start = 1; pass_sel = 0; n_blk = 4'd2; wait_c(40); start = 0; wait_c(15);
    go(0, 4'd1); wait_c(5); reset = 0; wait_c(1); reset = 1; wait_c(10);
    go(1, 4'd0); wait_c(12);
    go(0, 4'd15); wait_c(70);
    for (int i = 0; i < 2500; i++) begin
      start = $urandom_range(0, 3) == 0;
      pass_sel = 1'($urandom_range(0, 1));
      n_blk = 4'($urandom_range(0, 15));
      reset = $urandom_range(0, 150) != 0;
      @(negedge clk);
    end
    reset = 1; start = 0;
    wait_c(70);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drained_queue got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
